// File: rtl/cpu_regs_pkg.sv
// cpu_regs_pkg: shared register-file widths, write-back entry and source tag.
package cpu_regs_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } wb_entry_t;

    typedef enum logic [1:0] {WB_NONE, WB_PIPE, WB_LATE} wb_src_t;
endpackage

// File: rtl/wb_late_fifo.sv
// wb_late_fifo: synchronous FIFO of late write-back entries.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module wb_late_fifo
    import cpu_regs_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  wb_entry_t push_data,
    input  logic      pop,
    output wb_entry_t head,
    output logic      full,
    output logic      empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr, rd_ptr;
    wb_entry_t mem [DEPTH];

    assign empty = wr_ptr == rd_ptr;
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= push_data;
    end
endmodule

// File: rtl/reg_writeback_arb.sv
// reg_writeback_arb: merges in-order WB and late results onto the single
// register-file write port, tracking outstanding destinations in a scoreboard.
module reg_writeback_arb
    import cpu_regs_pkg::*;
#(
    parameter int LATE_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic [REG_ADDR_W-1:0] pipeWrAddr,
    input  logic [REG_DATA_W-1:0] pipeWrData,
    input  logic                  issueValid,
    input  logic [REG_ADDR_W-1:0] issueAddr,
    input  logic                  lateValid,
    input  logic [REG_ADDR_W-1:0] lateAddr,
    input  logic [REG_DATA_W-1:0] lateData,
    output logic                  lateReady,
    input  logic [REG_ADDR_W-1:0] rsAddr,
    input  logic [REG_ADDR_W-1:0] rtAddr,
    input  logic [REG_ADDR_W-1:0] decRdAddr,
    output logic                  pendHazard,
    output logic                  starveReq,
    output logic [REG_ADDR_W-1:0] wrAddr,
    output logic [REG_DATA_W-1:0] wrData
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    wb_entry_t head;
    wb_src_t   src;
    logic      full, empty, push, pop, pipe_win;
    logic [31:0]   pending, pend_next;
    logic [CW-1:0] cnt, cnt_next;

    assign pipe_win   = pipeWrAddr != REG_ZERO;
    assign push       = lateValid & lateReady;
    assign pop        = ~stall & ~pipe_win & ~empty;
    assign lateReady  = ~rst & ~full;
    assign pendHazard = ~rst & (pending[rsAddr] | pending[rtAddr] | pending[decRdAddr]);
    assign starveReq  = ~rst & (cnt >= CW'(STARVE_LIMIT));

    wb_late_fifo #(.DEPTH(LATE_DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_data('{addr: lateAddr, data: lateData}),
        .pop      (pop),
        .head     (head),
        .full     (full),
        .empty    (empty)
    );

    // Clear lands on the same edge the file writes; a new issue wins over it.
    always_comb begin
        pend_next = pending;
        if (~stall && src == WB_LATE) pend_next[wrAddr] = 1'b0;
        if (issueValid && ~stall && issueAddr != REG_ZERO) pend_next[issueAddr] = 1'b1;
        pend_next[0] = 1'b0;
    end

    assign cnt_next = (empty || pop) ? '0 :
                      (~stall && pipe_win && cnt < CW'(STARVE_LIMIT)) ? cnt + 1'b1 : cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            wrAddr  <= REG_ZERO;
            wrData  <= '0;
            src     <= WB_NONE;
            pending <= '0;
            cnt     <= '0;
        end else begin
            if (~stall) begin
                if (pipe_win) begin
                    wrAddr <= pipeWrAddr;
                    wrData <= pipeWrData;
                    src    <= WB_PIPE;
                end else if (~empty) begin
                    wrAddr <= head.addr;
                    wrData <= head.data;
                    src    <= WB_LATE;
                end else begin
                    wrAddr <= REG_ZERO;
                    src    <= WB_NONE;
                end
            end
            pending <= pend_next;
            cnt     <= cnt_next;
        end
    end
endmodule

// File: tb/tb_reg_writeback_arb.sv
// tb_reg_writeback_arb: directed vectors with hand-computed expectations.
module tb_reg_writeback_arb;
    logic        clk = 1'b0;
    logic        rst, stall, issueValid, lateValid, lateReady, pendHazard, starveReq;
    logic [4:0]  pipeWrAddr, issueAddr, lateAddr, rsAddr, rtAddr, decRdAddr, wrAddr;
    logic [31:0] pipeWrData, lateData, wrData;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    reg_writeback_arb #(.LATE_DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .pipeWrAddr(pipeWrAddr), .pipeWrData(pipeWrData),
        .issueValid(issueValid), .issueAddr(issueAddr),
        .lateValid(lateValid), .lateAddr(lateAddr), .lateData(lateData),
        .lateReady(lateReady),
        .rsAddr(rsAddr), .rtAddr(rtAddr), .decRdAddr(decRdAddr),
        .pendHazard(pendHazard), .starveReq(starveReq),
        .wrAddr(wrAddr), .wrData(wrData)
    );

    // Upstream should never let a pipe write hit a pending register.
    always @(posedge clk)
        if (!rst && !stall && pipeWrAddr != 5'd0)
            assert (!dut.pending[pipeWrAddr]) else $warning("pipe write to pending r%0d", pipeWrAddr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic late(input logic v, input logic [4:0] a, input logic [31:0] d);
        lateValid = v;
        lateAddr  = a;
        lateData  = d;
    endtask

    initial begin
        rst = 1; stall = 0; pipeWrAddr = 0; pipeWrData = 0; issueValid = 0; issueAddr = 0;
        late(0, 0, 0); rsAddr = 0; rtAddr = 0; decRdAddr = 0;
        step(); step();
        check("rst_wraddr", wrAddr, 0);
        check("rst_wrdata", wrData, 0);
        check("rst_ready", lateReady, 0);
        check("rst_hazard", pendHazard, 0);
        check("rst_starve", starveReq, 0);
        rst = 0;

        // pipe only
        pipeWrAddr = 3; pipeWrData = 32'hDEADBEEF;
        step(); pipeWrAddr = 0;
        check("pipe_addr", wrAddr, 3);
        check("pipe_data", wrData, 32'hDEADBEEF);
        step();
        check("pipe_idle_addr", wrAddr, 0);
        check("pipe_idle_data", wrData, 32'hDEADBEEF);

        // scoreboard set/clear through a late result
        issueValid = 1; issueAddr = 8; rsAddr = 8;
        check("sb_pre", pendHazard, 0);
        step(); issueValid = 0;
        check("sb_set", pendHazard, 1);
        late(1, 8, 32'h1234);
        check("sb_ready", lateReady, 1);
        step(); late(0, 0, 0);
        check("sb_fifo_lat", wrAddr, 0);
        step();
        check("sb_late_addr", wrAddr, 8);
        check("sb_late_data", wrData, 32'h1234);
        check("sb_still_pend", pendHazard, 1);
        step();
        check("sb_clear", pendHazard, 0);
        check("sb_idle", wrAddr, 0);
        rsAddr = 0;

        // starvation: pipe keeps winning while one late entry waits
        pipeWrAddr = 5; pipeWrData = 32'h55; late(1, 9, 32'h99);
        step(); late(0, 0, 0);
        check("st_pipe", wrAddr, 5);
        step(); step(); step();
        check("st_below", starveReq, 0);
        step();
        check("st_req", starveReq, 1);
        check("st_pipe_wins", wrAddr, 5);
        step();
        check("st_saturate", starveReq, 1);
        pipeWrAddr = 0;
        step();
        check("st_late_addr", wrAddr, 9);
        check("st_late_data", wrData, 32'h99);
        check("st_cleared", starveReq, 0);

        // full FIFO under pipe pressure
        pipeWrAddr = 6; pipeWrData = 32'h66; late(1, 10, 32'hA);
        check("ff_ready0", lateReady, 1);
        step(); late(1, 11, 32'hB);
        check("ff_ready1", lateReady, 1);
        step(); late(1, 12, 32'hC);
        check("ff_full", lateReady, 0);
        step();
        check("ff_full_hold", lateReady, 0);
        check("ff_pipe", wrAddr, 6);
        pipeWrAddr = 0;
        step();
        check("ff_deq_a", wrAddr, 10);
        check("ff_ready_after", lateReady, 1);
        step(); late(0, 0, 0);
        check("ff_deq_b", wrAddr, 11);
        step();
        check("ff_deq_c", wrAddr, 12);
        check("ff_deq_c_data", wrData, 32'hC);
        step();
        check("ff_empty", wrAddr, 0);

        // stall holds the output and the pending bit while the FIFO still fills
        issueValid = 1; issueAddr = 13; late(1, 13, 32'hD);
        step(); issueValid = 0; late(0, 0, 0);
        step();
        check("sl_late", wrAddr, 13);
        stall = 1; rtAddr = 13; late(1, 14, 32'hE);
        step();
        check("sl_hold_addr", wrAddr, 13);
        check("sl_hold_data", wrData, 32'hD);
        check("sl_pend", pendHazard, 1);
        check("sl_one_in", lateReady, 1);
        late(1, 15, 32'hF);
        step(); late(0, 0, 0);
        check("sl_two_in", lateReady, 0);
        check("sl_hold2", wrAddr, 13);
        stall = 0;
        step();
        check("sl_clear", pendHazard, 0);
        check("sl_next_addr", wrAddr, 14);
        check("sl_next_data", wrData, 32'hE);
        rtAddr = 0;

        // reset with two entries queued
        pipeWrAddr = 7; pipeWrData = 32'h77; late(1, 16, 32'h10);
        issueValid = 1; issueAddr = 20; rsAddr = 20;
        step(); late(0, 0, 0); issueValid = 0;
        check("rs_full", lateReady, 0);
        check("rs_pend", pendHazard, 1);
        rst = 1; pipeWrAddr = 0;
        step();
        check("rs_wraddr", wrAddr, 0);
        check("rs_ready_in", lateReady, 0);
        check("rs_hazard_in", pendHazard, 0);
        rst = 0;
        #1;
        check("rs_ready_out", lateReady, 1);
        check("rs_hazard_out", pendHazard, 0);
        step();
        check("rs_discard", wrAddr, 0);
        rsAddr = 0;

        // zero destinations: no scoreboard effect, no write
        issueValid = 1; issueAddr = 0; late(1, 0, 32'h77);
        step(); issueValid = 0; late(0, 0, 0);
        check("z_hazard", pendHazard, 0);
        step();
        check("z_noaddr", wrAddr, 0);
        check("z_ready", lateReady, 1);
        issueValid = 1; issueAddr = 21; decRdAddr = 21;
        step(); issueValid = 0;
        check("waw_hazard", pendHazard, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/reg_writeback_arb.md
Name: reg_writeback_arb

Overview:
- Producer side of the 4-port register file: merges the pipeline's in-order write-back stream and a long-latency result stream into the file's single write port.
- Long-latency sources are the multi-cycle multiply/divide-to-GPR unit and cache-miss loads.
- Holds a 32-entry pending scoreboard so decode can stall on registers whose results are still outstanding.
- Sits between the pipeline WB stage / long-latency units and the register file write port (write address and write data).

Parameters:
- LATE_DEPTH, 2, entries in the late-result FIFO (power of two, at least 2).
- STARVE_LIMIT, 4, cycles a late result may wait at the FIFO head before starveReq asserts.

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  pipeline stall; the register file write enable is already gated by ~stall.
- pipeWrAddr  in  5  in-order WB destination; 0 means no write.
- pipeWrData  in  32  in-order WB data.
- issueValid  in  1  a long-latency op issues this cycle.
- issueAddr  in  5  destination of the issuing long-latency op.
- lateValid  in  1  late result offered.
- lateAddr  in  5  late result destination.
- lateData  in  32  late result data.
- lateReady  out  1  late result accepted on this edge when lateValid is also high.
- rsAddr  in  5  decode read address for the pending check.
- rtAddr  in  5  decode read address for the pending check.
- decRdAddr  in  5  decode destination, used for the WAW check.
- pendHazard  out  1  combinational; a decode operand or destination is pending.
- starveReq  out  1  request to the control unit to insert one WB bubble.
- wrAddr  out  5  registered; drives the register file write address.
- wrData  out  32  registered; drives the register file write data.

Behaviour:
- Reset: scoreboard all 0, FIFO empty, wrAddr = 0, wrData = 0, starve counter = 0.
- During reset: lateReady = 0, pendHazard = 0, starveReq = 0.
- Scoreboard: 32 bits; bit 0 is hard-wired to 0.
- Scoreboard set: on an edge with issueValid & ~stall & (issueAddr != 0), set pending[issueAddr].
- Scoreboard clear: on an edge with ~stall where the output register currently holds a late entry, clear pending[wrAddr]. This is the same edge the register file writes, so a decode read in the next cycle sees the new value.
- Set and clear of the same address on one edge: set wins.
- pendHazard = pending[rsAddr] | pending[rtAddr] | pending[decRdAddr].
- Late FIFO: lateReady = ~full.
- Enqueue on lateValid & lateReady. Enqueue is allowed even when stall = 1.
- An entry with lateAddr = 0 is enqueued, and later dequeues as a no-write (wrAddr = 0) with no scoreboard effect.
- Output register is loaded only when stall = 0; when stall = 1 it holds, and no dequeue occurs.
- Priority when stall = 0:
  - pipeWrAddr != 0: load {pipeWrAddr, pipeWrData}; tag = pipe.
  - else if FIFO is non-empty: load the FIFO head and dequeue it; tag = late.
  - else: load wrAddr = 0; wrData holds its previous value.
- Latency: pipe write reaches wrAddr/wrData 1 cycle after presentation.
- Latency: late write reaches wrAddr/wrData at least 2 cycles after acceptance (FIFO, then output register).
- Full and empty on the same edge: enqueue and dequeue in one cycle are both legal, including when full (dequeue frees the slot only on the next cycle, so lateReady stays 0 that cycle).
- Wrap-around: FIFO pointers are log2(LATE_DEPTH)+1 bits, so full is distinguishable from empty.
- Starvation counter:
  - Increments on each ~stall cycle in which the FIFO is non-empty and a pipe write wins.
  - Resets to 0 on dequeue or when the FIFO is empty.
  - starveReq = (count >= STARVE_LIMIT); the counter saturates.
  - Control must respond with a cycle of pipeWrAddr = 0.
- Pipe write to a pending address is prevented upstream by pendHazard. If it does occur, the pipe write proceeds and the bench flags it with an assertion.
- Reset mid-operation discards FIFO contents and the scoreboard; wrAddr = 0 on the edge after rst is sampled.

Decomposition:
- Shared package cpu_regs_pkg:
  - REG_ADDR_W = 5, REG_DATA_W = 32, REG_ZERO = 5'd0.
  - Struct wb_entry_t {addr, data}.
  - Enum wb_src_t {WB_NONE, WB_PIPE, WB_LATE}.
- One sub-module, wb_late_fifo: parameterised synchronous FIFO of wb_entry_t with push/pop/full/empty.
- Scoreboard, arbiter and starve counter stay in the top module.

Test Plan:
- Pipe only: pipeWrAddr=3, pipeWrData=0xDEADBEEF for 1 cycle -> next cycle wrAddr=3, wrData=0xDEADBEEF; following cycle wrAddr=0.
- Scoreboard: issue to r8, rsAddr=8 -> pendHazard=1 from the next cycle. Late {8, 0x1234} accepted with no pipe traffic -> wrAddr=8 two cycles later; pendHazard drops the cycle after that.
- Priority and starvation: continuous pipe writes, one late entry queued -> starveReq=1 after 4 cycles. Then one cycle of pipeWrAddr=0 -> late entry written, starveReq=0.
- Full FIFO: pipe writes every cycle, 3 late offers -> lateReady=0 after 2 accepts. The third is accepted the cycle after the first dequeue.
- Stall: stall=1 with late entry at output and FIFO push -> wrAddr/wrData held, pending bit kept, FIFO count increases by 1. Release stall -> bit clears on the first ~stall edge.
- Reset and edge cases: rst during FIFO occupancy of 2 -> wrAddr=0, pendHazard=0, lateReady=1 after rst drops. issueAddr=0 or lateAddr=0 -> no scoreboard change, no write.
